// File: rtl/core_mc.sv
// Multi-cycle MIPS-subset core with req/ack instruction and data ports and a memory-mapped stdout register.
// Optional macro CORE_MC_ILLEGAL_TRAP_EN: undefined encodings halt the core instead of executing as NOPs.
module core_mc #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] STDOUT_ADDR = 32'hFFFF_FFFC,
   parameter int          NREGS       = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] pc,
   output logic [31:0] stdout,
   output logic        stdout_valid,
   output logic        halted,
   output logic [2:0]  dbg_state
);

   localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t state, state_next;

   logic [31:0] ir, a, b, target, res, addr_q;
   logic [31:0] regs [NREGS];

   logic [5:0]    op, funct;
   logic [RW-1:0] rs, rt, rd, dest;
   logic [31:0]   imm_sext, jump_target, alu_out;
   logic          funct_ok, is_alu, is_lw, is_sw, is_br, is_j, is_halt, taken, stdout_hit;
   logic          unused_bits;

   assign op          = ir[31:26];
   assign funct       = ir[5:0];
   assign rs          = ir[21 +: RW];
   assign rt          = ir[16 +: RW];
   assign rd          = ir[11 +: RW];
   assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
   assign jump_target = {pc[31:28], ir[25:0], 2'b00};
   assign dest        = (op == OP_R) ? rd : rt;
   assign unused_bits = ^{ir[10:6], addr_q[1:0]};

   always_comb begin
      funct_ok = 1'b0;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
         default:                               funct_ok = 1'b0;
      endcase
   end

   assign is_alu     = ((op == OP_R) && funct_ok) || (op == OP_ADDI);
   assign is_lw      = (op == OP_LW);
   assign is_sw      = (op == OP_SW);
   assign is_br      = (op == OP_BEQ) || (op == OP_BNE);
   assign is_j       = (op == OP_J);
   assign is_halt    = (op == OP_HALT);
   assign taken      = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));
   // Stores to the stdout word never reach the data port.
   assign stdout_hit = is_sw && ({addr_q[31:2], 2'b00} == STDOUT_ADDR);

   always_comb begin
      alu_out = a + imm_sext;
      if (op == OP_R) begin
         case (funct)
            FN_ADD:  alu_out = a + b;
            FN_SUB:  alu_out = a - b;
            FN_AND:  alu_out = a & b;
            FN_OR:   alu_out = a | b;
            FN_SLT:  alu_out = {31'd0, $signed(a) < $signed(b)};
            default: alu_out = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_next;
   end

   // Handshakes: a request stays high with its address/data stable until the
   // cycle its ack is seen; an ack while the request is low is ignored.
   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      case (state)
         FETCH: begin
            imem_req = reset;
            if (reset && imem_ack) state_next = DECODE;
         end
         DECODE: state_next = EXEC;
         EXEC: begin
            if (is_alu)              state_next = WB;
            else if (is_lw || is_sw) state_next = MEM;
            else if (is_br || is_j)  state_next = FETCH;
            else if (is_halt)        state_next = HALT;
            else begin
`ifdef CORE_MC_ILLEGAL_TRAP_EN
               state_next = HALT;
`else
               state_next = FETCH;
`endif
            end
         end
         MEM: begin
            if (stdout_hit) state_next = FETCH;
            else begin
               dmem_req = 1'b1;
               if (dmem_ack) begin
                  if (is_lw) state_next = WB;
                  else       state_next = FETCH;
               end
            end
         end
         WB:      state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc           <= RESET_PC;
         ir           <= '0;
         a            <= '0;
         b            <= '0;
         target       <= '0;
         res          <= '0;
         addr_q       <= '0;
         stdout       <= '0;
         stdout_valid <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         stdout_valid <= 1'b0;
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  ir <= imem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            DECODE: begin
               a      <= regs[rs];
               b      <= regs[rt];
               target <= pc + {imm_sext[29:0], 2'b00};
            end
            EXEC: begin
               res    <= alu_out;
               addr_q <= a + imm_sext;
               if (is_j)       pc <= jump_target;
               else if (taken) pc <= target;
            end
            MEM: begin
               if (stdout_hit) begin
                  stdout       <= b;
                  stdout_valid <= 1'b1;
               end else if (dmem_ack && is_lw) begin
                  res <= dmem_rdata;
               end
            end
            WB: begin
               if (dest != '0) regs[dest] <= res;
            end
            default: ;
         endcase
      end
   end

   assign imem_addr  = pc;
   assign dmem_we    = dmem_req && is_sw;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_wdata = b;
   assign halted     = (state == HALT);
   assign dbg_state  = state;

endmodule
